// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: glyph table for hex digits 0-F, blank pattern and encoder.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Entry n is the active-high a..g pattern for nibble n (bit0 = a).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg7_digit_chain.sv
// NUM_DIGITS x RADIX up/down counter; carry/borrow ripples from digit 0 upward and
// wrap pulses on the same edge the whole chain rolls over.
module seg7_digit_chain
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int RADIX      = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    step,
  input  logic                    up,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    wrap
);

  localparam logic [3:0] DIGIT_MAX = 4'(RADIX - 1);

  logic [4*NUM_DIGITS-1:0] value_q, value_d, value_step;
  logic                    wrap_q, wrap_d;
  logic                    ripple;

  // ripple is still set after the last digit only when every digit rolled over.
  always_comb begin
    value_step = value_q;
    ripple     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (ripple) begin
        if (up) begin
          if (value_q[4*i +: 4] == DIGIT_MAX) begin
            value_step[4*i +: 4] = 4'd0;
          end else begin
            value_step[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
            ripple               = 1'b0;
          end
        end else begin
          if (value_q[4*i +: 4] == 4'd0) begin
            value_step[4*i +: 4] = DIGIT_MAX;
          end else begin
            value_step[4*i +: 4] = value_q[4*i +: 4] - 4'd1;
            ripple               = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    value_d = value_q;
    wrap_d  = 1'b0;
    if (reset || clear) begin
      value_d = '0;
    end else if (step) begin
      value_d = value_step;
      wrap_d  = ripple;
    end
  end

  always_ff @(posedge clk) begin
    value_q <= value_d;
    wrap_q  <= wrap_d;
  end

  assign value = value_q;
  assign wrap  = wrap_q;

endmodule

// File: rtl/seg7_multi_counter.sv
// Prescaled N-digit up/down counter with a time-multiplexed 7-segment scan.
// Optional SEG7_LEAD_BLANK_EN: blank leading zero digits (digit 0 always shown).
module seg7_multi_counter
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int RADIX          = 10,
  parameter int TICK_W         = 24,
  parameter int DEFAULT_PERIOD = 10_000_000,
  parameter int SCAN_DIV       = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    up,
  input  logic                    clear,
  input  logic [TICK_W-1:0]       period,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    tick,
  output logic                    wrap,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_sel
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [TICK_W-1:0] DEFAULT_TC = TICK_W'(DEFAULT_PERIOD);
  localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [TICK_W-1:0]       pcnt_q, pcnt_d, term;
  logic [SCAN_W-1:0]       scnt_q, scnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic [4*NUM_DIGITS-1:0] value_int, shifted;
  logic                    tick_int;

  assign term     = (period == '0) ? DEFAULT_TC : period;
  assign tick_int = run && !reset && (pcnt_q == term);

  // >= also catches a count stranded above a newly lowered period; that path never ticks.
  always_comb begin
    pcnt_d = pcnt_q;
    if (reset || clear) begin
      pcnt_d = '0;
    end else if (run) begin
      if (pcnt_q >= term) pcnt_d = '0;
      else                pcnt_d = pcnt_q + TICK_W'(1);
    end
  end

  seg7_digit_chain #(
    .NUM_DIGITS (NUM_DIGITS),
    .RADIX      (RADIX)
  ) u_chain (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .step  (tick_int),
    .up    (up),
    .value (value_int),
    .wrap  (wrap)
  );

  always_comb begin
    scnt_d = scnt_q;
    idx_d  = idx_q;
    if (reset) begin
      scnt_d = '0;
      idx_d  = '0;
    end else if (scnt_q == SCAN_LAST) begin
      scnt_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      scnt_d = scnt_q + SCAN_W'(1);
    end
  end

  assign shifted = value_int >> (4 * int'(idx_q));

  always_comb begin
    seg_d = seg7_encode(shifted[3:0]);
    sel_d = NUM_DIGITS'(1) << idx_q;
`ifdef SEG7_LEAD_BLANK_EN
    if (idx_q != '0 && shifted == '0) seg_d = SEG_BLANK;
`endif
    if (reset) begin
      seg_d = '0;
      sel_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    pcnt_q <= pcnt_d;
    scnt_q <= scnt_d;
    idx_q  <= idx_d;
    seg_q  <= seg_d;
    sel_q  <= sel_d;
  end

  assign value     = value_int;
  assign tick      = tick_int;
  assign seg_out   = seg_q;
  assign digit_sel = sel_q;

endmodule

// File: tb/tb_seg7_multi_counter.sv
// Scoreboard bench: two 2-digit instances (BCD with SCAN_DIV=2, hex) driven with directed vectors.
module tb_seg7_multi_counter;

  typedef struct {
    logic [7:0] value;
    logic       wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run_a = 1'b0, up_a = 1'b1, clear_a = 1'b0;
  logic [7:0] period_a = 8'd3;
  logic [7:0] value_a;
  logic       tick_a, wrap_a;
  logic [6:0] seg_a;
  logic [1:0] sel_a;

  logic       run_b = 1'b0, up_b = 1'b0, clear_b = 1'b0;
  logic [7:0] period_b = 8'd3;
  logic [7:0] value_b;
  logic       tick_b, wrap_b;
  logic [6:0] seg_b;
  logic [1:0] sel_b;

  int   errors = 0;
  int   checks = 0;
  exp_t qa[$];
  exp_t qb[$];
  bit   pend_a = 0, post_a = 0, pend_b = 0, post_b = 0;

  always #5 clk = ~clk;

  seg7_multi_counter #(
    .NUM_DIGITS(2), .RADIX(10), .TICK_W(8), .DEFAULT_PERIOD(5), .SCAN_DIV(2)
  ) dut_a (
    .clk(clk), .reset(reset), .run(run_a), .up(up_a), .clear(clear_a),
    .period(period_a), .value(value_a), .tick(tick_a), .wrap(wrap_a),
    .seg_out(seg_a), .digit_sel(sel_a)
  );

  seg7_multi_counter #(
    .NUM_DIGITS(2), .RADIX(16), .TICK_W(8), .DEFAULT_PERIOD(5), .SCAN_DIV(4)
  ) dut_b (
    .clk(clk), .reset(reset), .run(run_b), .up(up_b), .clear(clear_b),
    .period(period_b), .value(value_b), .tick(tick_b), .wrap(wrap_b),
    .seg_out(seg_b), .digit_sel(sel_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  task automatic push_a(input logic [7:0] v, input logic w);
    exp_t e;
    e.value = v;
    e.wrap  = w;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [7:0] v, input logic w);
    exp_t e;
    e.value = v;
    e.wrap  = w;
    qb.push_back(e);
  endtask

  task automatic wait_empty_a(input int budget);
    int n = 0;
    while (qa.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (qa.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_a: %0d updates still pending, required 0", qa.size());
      qa.delete();
    end
  endtask

  task automatic wait_empty_b(input int budget);
    int n = 0;
    while (qb.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (qb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_b: %0d updates still pending, required 0", qb.size());
      qb.delete();
    end
  endtask

  // A tick seen before an edge means value/wrap change on that edge; compare one half-cycle after it.
  always @(negedge clk) begin
    exp_t e;
    if (post_a) begin
      chk("wrap_single_a", wrap_a, 0);
      post_a = 0;
    end
    if (pend_a) begin
      pend_a = 0;
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_update_a: got value %0h, required no update", value_a);
      end else begin
        e = qa.pop_front();
        chk("value_a", value_a, e.value);
        chk("wrap_a", wrap_a, e.wrap);
        post_a = 1;
      end
    end
    if (tick_a && !reset && !clear_a) pend_a = 1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (post_b) begin
      chk("wrap_single_b", wrap_b, 0);
      post_b = 0;
    end
    if (pend_b) begin
      pend_b = 0;
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_update_b: got value %0h, required no update", value_b);
      end else begin
        e = qb.pop_front();
        chk("value_b", value_b, e.value);
        chk("wrap_b", wrap_b, e.wrap);
        post_b = 1;
      end
    end
    if (tick_b && !reset && !clear_b) pend_b = 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    bit         found;
    logic [1:0] prev;
    logic [6:0] seg_hi;

`ifdef SEG7_LEAD_BLANK_EN
    seg_hi = 7'h00;
`else
    seg_hi = 7'h3F;
`endif

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_value", value_a, 0);
    chk("rst_tick", tick_a, 0);
    chk("rst_wrap", wrap_a, 0);
    chk("rst_seg", seg_a, 0);
    chk("rst_sel", sel_a, 0);
    chk("rst_value_b", value_b, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rel_sel", sel_a, 2'b01);
    chk("rel_seg", seg_a, 7'h3F);

    // BCD count 00 -> 10, tick every period+1 cycles
    run_a = 1'b1;
    up_a  = 1'b1;
    for (int i = 1; i <= 10; i++) push_a(bcd(i), 1'b0);
    n = 0;
    while (!tick_a && n < 20) begin @(posedge clk); #1; n++; end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!tick_a && n < 20);
    chk("tick_interval", n, 4);
    wait_empty_a(100);

    // on to 99, then full-chain wrap
    for (int i = 11; i <= 99; i++) push_a(bcd(i), 1'b0);
    push_a(8'h00, 1'b1);
    push_a(8'h01, 1'b0);
    wait_empty_a(500);

    // clear coincident with a tick at 42
    for (int i = 2; i <= 42; i++) push_a(bcd(i), 1'b0);
    wait_empty_a(250);
    repeat (3) @(posedge clk);
    #1;
    chk("clr_tick_present", tick_a, 1);
    clear_a = 1'b1;
    @(posedge clk); #1;
    clear_a = 1'b0;
    chk("clr_value", value_a, 0);
    chk("clr_wrap", wrap_a, 0);
    chk("clr_no_tick", tick_a, 0);
    push_a(8'h01, 1'b0);
    n = 0;
    while (!tick_a && n < 20) begin @(posedge clk); #1; n++; end
    chk("clr_restart", n, 3);
    wait_empty_a(20);

    // period lowered below the running count
    period_a = 8'd10;
    repeat (7) @(posedge clk);
    #1;
    period_a = 8'd3;
    chk("shrink_no_tick", tick_a, 0);
    push_a(8'h02, 1'b0);
    @(posedge clk); #1;
    chk("shrink_reset", tick_a, 0);
    n = 0;
    while (!tick_a && n < 20) begin @(posedge clk); #1; n++; end
    chk("shrink_restart", n, 3);
    wait_empty_a(20);

    // scan at value 05 with run frozen
    for (int i = 3; i <= 5; i++) push_a(bcd(i), 1'b0);
    wait_empty_a(50);
    run_a = 1'b0;
    found = 0;
    prev  = sel_a;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (sel_a == 2'b01 && prev == 2'b10) found = 1;
      else prev = sel_a;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL scan_lock: digit_sel %0h never stepped 10->01", sel_a);
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (k > 0) @(negedge clk);
        chk("scan_sel", sel_a, ((k >> 1) & 1) ? 2'b10 : 2'b01);
        chk("scan_seg", seg_a, ((k >> 1) & 1) ? seg_hi : 7'h6D);
      end
      chk("frozen_value", value_a, 8'h05);
    end

    // hex count down from 00
    run_b  = 1'b1;
    up_b   = 1'b0;
    push_b(8'hFF, 1'b1);
    push_b(8'hFE, 1'b0);
    wait_empty_b(40);
    run_b = 1'b0;

    // reset mid-count at 37
    run_a = 1'b1;
    for (int i = 6; i <= 37; i++) push_a(bcd(i), 1'b0);
    wait_empty_a(300);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_value", value_a, 0);
    chk("mid_rst_tick", tick_a, 0);
    chk("mid_rst_wrap", wrap_a, 0);
    chk("mid_rst_seg", seg_a, 0);
    chk("mid_rst_sel", sel_a, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rel_sel", sel_a, 2'b01);
    chk("mid_rel_seg", seg_a, 7'h3F);
    push_a(8'h01, 1'b0);
    wait_empty_a(20);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
